// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl shared definitions: forward-select encoding,
// instruction field positions and legal pipeline limits.
package pipe_ctrl_pkg;

   localparam logic [2:0] FWD_RF = 3'd0;

   localparam int RD_LO  = 7;
   localparam int RS1_LO = 15;
   localparam int RS2_LO = 20;
   localparam int REG_W  = 5;

   localparam int NSTAGE_MIN = 2;
   localparam int NSTAGE_MAX = 6;

   typedef struct packed {
      logic valid;
      logic we;
      logic load;
   } ctl_t;

   function automatic logic [REG_W-1:0] fld(
      input logic [31:0] inst,
      input int          lo
   );
      return inst[lo +: REG_W];
   endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Fetch-side inputs and per-stage status outputs of pipe_ctrl.
interface pipe_ctrl_if #(
   parameter int XLEN   = 32,
   parameter int NSTAGE = 3
);

   logic                       in_valid;
   logic [XLEN-1:0]            in_pc;
   logic [31:0]                in_inst;
   logic                       in_we;
   logic                       in_load;
   logic                       redirect;
   logic                       stall_out;
   logic [NSTAGE-2:0]          st_valid;
   logic [(NSTAGE-1)*XLEN-1:0] st_pc;
   logic [(NSTAGE-1)*32-1:0]   st_inst;
   logic [2:0]                 fwd_a_sel;
   logic [2:0]                 fwd_b_sel;

   modport master (
      output in_valid, in_pc, in_inst,
      output in_we, in_load, redirect,
      input  stall_out, st_valid,
      input  st_pc, st_inst,
      input  fwd_a_sel, fwd_b_sel
   );

   modport slave (
      input  in_valid, in_pc, in_inst,
      input  in_we, in_load, redirect,
      output stall_out, st_valid,
      output st_pc, st_inst,
      output fwd_a_sel, fwd_b_sel
   );

endinterface

// File: rtl/pipe_ctrl_slot.sv
// One pipeline stage register; hold wins over bubble,
// and a bubble clears only the control bits.
module pipe_slot
   import pipe_ctrl_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            hold_i,
   input  logic            bubble_i,
   input  ctl_t            ctl_i,
   input  logic [XLEN-1:0] pc_i,
   input  logic [31:0]     inst_i,
   output ctl_t            ctl_o,
   output logic [XLEN-1:0] pc_o,
   output logic [31:0]     inst_o
);

   ctl_t            ctl_q, ctl_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [31:0]     inst_q, inst_d;

   always_comb begin
      ctl_d  = ctl_q;
      pc_d   = pc_q;
      inst_d = inst_q;
      priority case (1'b1)
         hold_i:   ;
         bubble_i: ctl_d = '0;
         default: begin
            ctl_d  = ctl_i;
            pc_d   = pc_i;
            inst_d = inst_i;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         ctl_q  <= '0;
         pc_q   <= '0;
         inst_q <= '0;
      end else begin
         ctl_q  <= ctl_d;
         pc_q   <= pc_d;
         inst_q <= inst_d;
      end
   end

   assign ctl_o  = ctl_q;
   assign pc_o   = pc_q;
   assign inst_o = inst_q;

endmodule

// File: rtl/pipe_ctrl.sv
// In-order pipeline control: stage registers, operand
// forwarding from the youngest producer, load-use stall.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter int NSTAGE   = 3,
   parameter int LOAD_STG = NSTAGE - 1
) (
   input logic       clk,
   input logic       rst,
   pipe_ctrl_if.slave bus
);

   if (NSTAGE < NSTAGE_MIN || NSTAGE > NSTAGE_MAX) begin : g_bad
      $error("pipe_ctrl: NSTAGE out of range");
   end

   // index 0 is the unregistered fetch stage
   ctl_t            s_ctl  [NSTAGE];
   logic [XLEN-1:0] s_pc   [NSTAGE];
   logic [31:0]     s_inst [NSTAGE];

   logic             stall;
   logic             ld_a, ld_b;
   logic [2:0]       sel_a, sel_b;
   logic [REG_W-1:0] rs1, rs2, rd_k;

   assign s_ctl[0]  = {bus.in_valid, bus.in_we, bus.in_load};
   assign s_pc[0]   = bus.in_pc;
   assign s_inst[0] = bus.in_inst;

   for (genvar k = 1; k < NSTAGE; k++) begin : g_slot
      logic hold_w, bub_w;

      if (k == 1) begin : g_first
         assign hold_w = stall;
         assign bub_w  = bus.redirect & ~stall;
      end else if (k == 2) begin : g_second
         assign hold_w = 1'b0;
         assign bub_w  = stall;
      end else begin : g_rest
         assign hold_w = 1'b0;
         assign bub_w  = 1'b0;
      end

      pipe_slot #(.XLEN(XLEN)) u_slot (
         .clk      (clk),
         .rst      (rst),
         .hold_i   (hold_w),
         .bubble_i (bub_w),
         .ctl_i    (s_ctl[k-1]),
         .pc_i     (s_pc[k-1]),
         .inst_i   (s_inst[k-1]),
         .ctl_o    (s_ctl[k]),
         .pc_o     (s_pc[k]),
         .inst_o   (s_inst[k])
      );

      assign bus.st_valid[k-1] = s_ctl[k].valid;
      assign bus.st_pc[(k-1)*XLEN +: XLEN] = s_pc[k];
      assign bus.st_inst[(k-1)*32 +: 32]   = s_inst[k];
   end

   assign rs1 = fld(s_inst[1], RS1_LO);
   assign rs2 = fld(s_inst[1], RS2_LO);

   // oldest first so the youngest match is the last one written
   always_comb begin
      sel_a = FWD_RF;
      sel_b = FWD_RF;
      ld_a  = 1'b0;
      ld_b  = 1'b0;
      rd_k  = '0;
      for (int k = NSTAGE - 1; k >= 2; k--) begin
         rd_k = fld(s_inst[k], RD_LO);
         if (s_ctl[1].valid && s_ctl[k].valid &&
             s_ctl[k].we && rd_k != '0) begin
            if (rd_k == rs1) begin
               sel_a = 3'(k);
               ld_a  = s_ctl[k].load && (k < LOAD_STG);
            end
            if (rd_k == rs2) begin
               sel_b = 3'(k);
               ld_b  = s_ctl[k].load && (k < LOAD_STG);
            end
         end
      end
   end

   assign stall         = ld_a | ld_b;
   assign bus.stall_out = stall;
   assign bus.fwd_a_sel = stall ? FWD_RF : sel_a;
   assign bus.fwd_b_sel = stall ? FWD_RF : sel_b;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: five depths driven by one stream,
// each checked every cycle against a shift-queue model.
module tb_pipe_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_we = 1'b0;
   logic        in_load = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] in_pc = '0;
   logic [31:0] in_inst = '0;

   int vectors = 0;
   int miscompares = 0;
   bit armed = 1'b0;

   always #5 clk = ~clk;

   typedef struct packed {
      logic        v;
      logic        we;
      logic        ld;
      logic [31:0] pc;
      logic [31:0] inst;
   } rec_t;

   localparam int NS  [5] = '{2, 3, 4, 5, 6};
   localparam int LSA [5] = '{1, 2, 3, 3, 4};

   for (genvar gi = 0; gi < 5; gi++) begin : cfg
      localparam int N  = NS[gi];
      localparam int LS = LSA[gi];

      pipe_ctrl_if #(.XLEN(32), .NSTAGE(N)) bus ();

      assign bus.in_valid = in_valid;
      assign bus.in_pc    = in_pc;
      assign bus.in_inst  = in_inst;
      assign bus.in_we    = in_we;
      assign bus.in_load  = in_load;
      assign bus.redirect = redirect;

      pipe_ctrl #(
         .XLEN(32), .NSTAGE(N), .LOAD_STG(LS)
      ) dut (
         .clk (clk),
         .rst (rst),
         .bus (bus)
      );

      rec_t p [7] = '{default: '0};

      // first in-flight writer found, scanning youngest first
      function automatic void haz(
         output logic       stl,
         output logic [2:0] fa,
         output logic [2:0] fb
      );
         logic       la, lb;
         logic [4:0] rd;
         la = 1'b0; lb = 1'b0; fa = 3'd0; fb = 3'd0;
         if (p[1].v) begin
            for (int k = 2; k < N; k++) begin
               rd = p[k].inst[11:7];
               if (p[k].v && p[k].we && rd != 5'd0) begin
                  if (fa == 3'd0 && rd == p[1].inst[19:15]) begin
                     fa = 3'(k);
                     la = p[k].ld && (k < LS);
                  end
                  if (fb == 3'd0 && rd == p[1].inst[24:20]) begin
                     fb = 3'(k);
                     lb = p[k].ld && (k < LS);
                  end
               end
            end
         end
         stl = la | lb;
         if (stl) begin
            fa = 3'd0;
            fb = 3'd0;
         end
      endfunction

      always @(posedge clk) begin
         logic       stl;
         logic [2:0] fa, fb;
         haz(stl, fa, fb);
         if (!rst) begin
            for (int k = 0; k < 7; k++) p[k] = '0;
         end else begin
            for (int k = N - 1; k >= 3; k--) p[k] = p[k-1];
            if (N > 2) begin
               if (stl) begin
                  p[2].v = 1'b0; p[2].we = 1'b0; p[2].ld = 1'b0;
               end else begin
                  p[2] = p[1];
               end
            end
            if (!stl) begin
               if (redirect) begin
                  p[1].v = 1'b0; p[1].we = 1'b0; p[1].ld = 1'b0;
               end else begin
                  p[1] = '{in_valid, in_we, in_load, in_pc, in_inst};
               end
            end
         end
      end

      always @(negedge clk) begin
         logic       stl;
         logic [2:0] fa, fb;
         logic [5:0] ev;
         bit         ok;
         if (armed) begin
            haz(stl, fa, fb);
            ev = '0;
            ok = (bus.stall_out === stl) &&
                 (bus.fwd_a_sel === fa) &&
                 (bus.fwd_b_sel === fb);
            for (int k = 1; k < N; k++) begin
               ev[k-1] = p[k].v;
               if (bus.st_pc[(k-1)*32 +: 32] !== p[k].pc ||
                   bus.st_inst[(k-1)*32 +: 32] !== p[k].inst)
                  ok = 1'b0;
            end
            if (bus.st_valid !== ev[N-2:0]) ok = 1'b0;
            vectors++;
            if (!ok) begin
               miscompares++;
               $display("FAIL model N=%0d t=%0t stall %b want %b fa %0d want %0d fb %0d want %0d valid %b want %b",
                        N, $time, bus.stall_out, stl, bus.fwd_a_sel, fa,
                        bus.fwd_b_sel, fb, bus.st_valid, ev[N-2:0]);
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s got %0h want %0h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] mk(input int rd, input int rs1,
                                      input int rs2);
      logic [4:0] a, b, c;
      a = rd[4:0]; b = rs1[4:0]; c = rs2[4:0];
      return {7'h0, c, b, 3'h0, a, 7'h33};
   endfunction

   task automatic put(input bit v, input logic [31:0] pc,
                      input logic [31:0] inst, input bit we,
                      input bit ld, input bit rdr);
      in_valid = v; in_pc = pc; in_inst = inst;
      in_we = we; in_load = ld; redirect = rdr;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) put(0, '0, '0, 0, 0, 0);
   endtask

   initial begin
      logic [31:0] ri;
      logic [31:0] rpc;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", cfg[2].bus.st_valid, 0);
      chk("rst_stall", cfg[2].bus.stall_out, 0);
      armed = 1'b1;
      rst = 1'b1;

      put(1, 32'h10, mk(5, 0, 0), 1, 0, 0);
      put(1, 32'h14, mk(6, 5, 5), 1, 0, 0);
      chk("alu_fwd_a", cfg[1].bus.fwd_a_sel, 2);
      chk("alu_fwd_b", cfg[1].bus.fwd_b_sel, 2);
      chk("alu_stall", cfg[1].bus.stall_out, 0);
      idle(6);

      put(1, 32'h20, mk(7, 0, 0), 1, 1, 0);
      put(1, 32'h24, mk(8, 7, 0), 1, 0, 0);
      chk("lu_stall", cfg[2].bus.stall_out, 1);
      chk("lu_sel0", cfg[2].bus.fwd_a_sel, 0);
      put(1, 32'h28, mk(0, 0, 0), 0, 0, 1);
      chk("lu_unstall", cfg[2].bus.stall_out, 0);
      chk("lu_fwd_a", cfg[2].bus.fwd_a_sel, 3);
      chk("lu_fwd_b", cfg[2].bus.fwd_b_sel, 0);
      chk("lu_valid", cfg[2].bus.st_valid, 3'b101);
      chk("lu_hold_pc", cfg[2].bus.st_pc[31:0], 32'h24);
      idle(6);

      put(1, 32'h30, mk(9, 0, 0), 1, 0, 0);
      put(1, 32'h34, mk(9, 0, 0), 1, 0, 0);
      put(1, 32'h38, mk(10, 9, 0), 1, 0, 0);
      chk("young_a", cfg[2].bus.fwd_a_sel, 2);
      chk("young_b", cfg[2].bus.fwd_b_sel, 0);
      put(1, 32'h3c, mk(0, 0, 0), 1, 0, 0);
      put(1, 32'h40, mk(11, 0, 0), 1, 0, 0);
      chk("x0_a", cfg[2].bus.fwd_a_sel, 0);
      chk("x0_b", cfg[2].bus.fwd_b_sel, 0);
      idle(6);

      put(1, 32'h100, mk(1, 0, 0), 0, 0, 0);
      put(1, 32'h104, mk(2, 0, 0), 0, 0, 1);
      chk("redir_s1v", cfg[2].bus.st_valid[0], 0);
      chk("redir_s2v", cfg[2].bus.st_valid[1], 1);
      chk("redir_s2pc", cfg[2].bus.st_pc[63:32], 32'h100);
      idle(6);

      put(1, 32'h200, mk(7, 0, 0), 1, 1, 0);
      put(1, 32'h204, mk(8, 7, 0), 1, 0, 0);
      chk("rs_stall", cfg[2].bus.stall_out, 1);
      rst = 1'b0;
      put(1, 32'h208, mk(3, 0, 0), 1, 0, 1);
      chk("rs_valid", cfg[2].bus.st_valid, 0);
      chk("rs_nostall", cfg[2].bus.stall_out, 0);
      rst = 1'b1;
      put(1, 32'h300, mk(4, 0, 0), 0, 0, 0);
      chk("rs_first_v", cfg[2].bus.st_valid[0], 1);
      chk("rs_first_pc", cfg[2].bus.st_pc[31:0], 32'h300);
      idle(6);

      rpc = 32'h1000;
      for (int i = 0; i < 400; i++) begin
         ri = $urandom;
         ri[11:7]  = 5'($urandom_range(0, 3));
         ri[19:15] = 5'($urandom_range(0, 3));
         ri[24:20] = 5'($urandom_range(0, 3));
         rst = ($urandom_range(0, 63) != 0);
         put($urandom_range(0, 3) != 0, rpc, ri,
             $urandom_range(0, 3) != 0,
             $urandom_range(0, 2) == 0,
             $urandom_range(0, 7) == 0);
         rpc += 32'd4;
      end
      rst = 1'b1;
      idle(8);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
